// File: rtl/vrp_dispatch_route.sv
// 1-to-N valid/ready dispatcher: routes each upstream payload to one of WIDTH outputs,
// each buffered by its own DEPTH-entry FIFO so a stalled slave never blocks the others.
module vrp_dispatch_route #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PLD_WIDTH = 32,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       vld_s,
    input  logic [PLD_WIDTH-1:0]       pld_s,
    input  logic [$clog2(WIDTH)-1:0]   dst_idx_s,
    output logic                       rdy_s,
    output logic [WIDTH-1:0]           v_vld_m,
    output logic [PLD_WIDTH-1:0]       v_pld_m [WIDTH-1:0],
    input  logic [WIDTH-1:0]           v_rdy_m,
    input  logic                       err_clr,
    output logic                       err_dst
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PtrLast = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);

    logic [PLD_WIDTH-1:0] mem_q    [WIDTH][DEPTH];
    logic [PLD_WIDTH-1:0] mem_d    [WIDTH][DEPTH];
    logic [PW-1:0]        wr_ptr_q [WIDTH];
    logic [PW-1:0]        wr_ptr_d [WIDTH];
    logic [PW-1:0]        rd_ptr_q [WIDTH];
    logic [PW-1:0]        rd_ptr_d [WIDTH];
    logic [CW-1:0]        cnt_q    [WIDTH];
    logic [CW-1:0]        cnt_d    [WIDTH];
    logic                 err_q;
    logic                 err_d;

    logic [WIDTH-1:0] full;
    logic [WIDTH-1:0] empty;
    logic [WIDTH-1:0] push;
    logic [WIDTH-1:0] pop;
    logic             dst_legal;
    logic             dst_full;
    logic             accept;

    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            full[i]  = (cnt_q[i] == CntFull);
            empty[i] = (cnt_q[i] == '0);
        end
    end

    // Decode the index by comparison so an out-of-range index never indexes past WIDTH.
    always_comb begin
        dst_legal = 1'b0;
        dst_full  = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (dst_idx_s == IW'(i)) begin
                dst_legal = 1'b1;
                dst_full  = full[i];
            end
        end
    end

    // Registered full only: no combinational path from v_rdy_m to rdy_s.
    assign rdy_s  = !dst_legal || !dst_full;
    assign accept = vld_s && rdy_s;

    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            push[i] = accept && dst_legal && (dst_idx_s == IW'(i));
            pop[i]  = !empty[i] && v_rdy_m[i];
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            cnt_d[i]    = cnt_q[i];
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = pld_s;
                wr_ptr_d[i] = (wr_ptr_q[i] == PtrLast) ? '0 : wr_ptr_q[i] + PW'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = (rd_ptr_q[i] == PtrLast) ? '0 : rd_ptr_q[i] + PW'(1);
            end
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (!push[i] && pop[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    // Set wins over clear when both occur in the same cycle.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (vld_s && !dst_legal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
            err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            v_vld_m[i] = !empty[i];
            v_pld_m[i] = mem_q[i][rd_ptr_q[i]];
        end
    end

    assign err_dst = err_q;

endmodule

// File: tb/tb_vrp_dispatch_route.sv
// Bench for vrp_dispatch_route: directed cases plus randomized traffic checked against
// per-destination payload queues; a second WIDTH=6 instance covers illegal indices.
module tb_vrp_dispatch_route;

    localparam int unsigned W     = 8;
    localparam int unsigned W6    = 6;
    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        rst_n;

    logic        vld_s;
    logic [31:0] pld_s;
    logic [2:0]  dst_idx_s;
    logic        rdy_s;
    logic [7:0]  v_vld_m;
    logic [31:0] v_pld_m [7:0];
    logic [7:0]  v_rdy_m;
    logic        err_clr;
    logic        err_dst;

    logic        vld6;
    logic [31:0] pld6;
    logic [2:0]  dst6;
    logic        rdy6;
    logic [5:0]  v_vld6;
    logic [31:0] v_pld6 [5:0];
    logic [5:0]  v_rdy6;
    logic        err_clr6;
    logic        err6;

    vrp_dispatch_route #(.WIDTH(W), .PLD_WIDTH(32), .DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld_s     (vld_s),
        .pld_s     (pld_s),
        .dst_idx_s (dst_idx_s),
        .rdy_s     (rdy_s),
        .v_vld_m   (v_vld_m),
        .v_pld_m   (v_pld_m),
        .v_rdy_m   (v_rdy_m),
        .err_clr   (err_clr),
        .err_dst   (err_dst)
    );

    vrp_dispatch_route #(.WIDTH(W6), .PLD_WIDTH(32), .DEPTH(DEPTH)) u_dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld_s     (vld6),
        .pld_s     (pld6),
        .dst_idx_s (dst6),
        .rdy_s     (rdy6),
        .v_vld_m   (v_vld6),
        .v_pld_m   (v_pld6),
        .v_rdy_m   (v_rdy6),
        .err_clr   (err_clr6),
        .err_dst   (err6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;
    logic [31:0] mq [W][$];
    logic        last_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Called just after a falling edge with inputs already driven; returns after the next one.
    task automatic step();
        logic       exp_rdy;
        logic [7:0] exp_vld;
        logic [7:0] saved;
        logic       acc;
        logic [7:0] pops;
        #1;
        exp_rdy = (mq[dst_idx_s].size() < DEPTH);
        for (int i = 0; i < W; i++) exp_vld[i] = (mq[i].size() != 0);
        check("rdy_s", {63'd0, rdy_s}, {63'd0, exp_rdy});
        check("v_vld_m", {56'd0, v_vld_m}, {56'd0, exp_vld});
        check("err_dst", {63'd0, err_dst}, 64'd0);
        for (int i = 0; i < W; i++) begin
            if (mq[i].size() != 0) check("v_pld_m", {32'd0, v_pld_m[i]}, {32'd0, mq[i][0]});
        end
        saved   = v_rdy_m;
        v_rdy_m = ~v_rdy_m;
        #1;
        check("rdy_indep", {63'd0, rdy_s}, {63'd0, exp_rdy});
        v_rdy_m = saved;
        acc        = vld_s && exp_rdy;
        pops       = exp_vld & v_rdy_m;
        last_stall = vld_s && !exp_rdy;
        @(posedge clk);
        for (int i = 0; i < W; i++) if (pops[i]) void'(mq[i].pop_front());
        if (acc) mq[dst_idx_s].push_back(pld_s);
        @(negedge clk);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        last_stall = 1'b0;
        rst_n      = 1'b0;
        vld_s      = 1'b0;
        pld_s      = '0;
        dst_idx_s  = '0;
        v_rdy_m    = '0;
        err_clr    = 1'b0;
        vld6       = 1'b0;
        pld6       = '0;
        dst6       = '0;
        v_rdy6     = '0;
        err_clr6   = 1'b0;

        // Reset state
        #3;
        check("rst_vld", {56'd0, v_vld_m}, 64'd0);
        check("rst_err", {63'd0, err_dst}, 64'd0);
        check("rst_rdy", {63'd0, rdy_s}, 64'd1);
        check("rst_pld0", {32'd0, v_pld_m[0]}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();

        // Single route to dst 3
        vld_s = 1'b1; dst_idx_s = 3'd3; pld_s = 32'hA5A5_0003;
        step();
        vld_s = 1'b0;
        #1;
        check("t2_vld", {56'd0, v_vld_m}, 64'h08);
        check("t2_pld", {32'd0, v_pld_m[3]}, 64'hA5A5_0003);
        v_rdy_m = 8'h08;
        step();
        #1;
        check("t2_drained", {56'd0, v_vld_m}, 64'h00);
        step();

        // Backpressure on dst 5
        v_rdy_m = 8'hDF;
        vld_s = 1'b1; dst_idx_s = 3'd5;
        pld_s = 32'h500; step();
        pld_s = 32'h501; step();
        pld_s = 32'h502;
        #1;
        check("t3_full_rdy", {63'd0, rdy_s}, 64'd0);
        step();
        vld_s = 1'b0; step();
        vld_s = 1'b1; dst_idx_s = 3'd1;
        pld_s = 32'h100; step();
        pld_s = 32'h101; step();
        #1;
        check("t3_head5", {32'd0, v_pld_m[5]}, 64'h500);
        v_rdy_m = 8'hFF; dst_idx_s = 3'd5; pld_s = 32'h502;
        step();
        step();
        vld_s = 1'b0;
        repeat (3) step();

        // Full FIFO with same-cycle pop
        v_rdy_m = 8'hFB;
        vld_s = 1'b1; dst_idx_s = 3'd2;
        pld_s = 32'h200; step();
        pld_s = 32'h201; step();
        v_rdy_m = 8'hFF; pld_s = 32'h202;
        #1;
        check("t4_full_pop_rdy", {63'd0, rdy_s}, 64'd0);
        step();
        #1;
        check("t4_next_rdy", {63'd0, rdy_s}, 64'd1);
        step();
        vld_s = 1'b0;
        repeat (3) step();

        // Randomized traffic
        for (int n = 0; n < 10000; n++) begin
            if (!last_stall) begin
                vld_s     = ($urandom_range(0, 3) != 0);
                dst_idx_s = 3'($urandom_range(0, W - 1));
                pld_s     = $urandom();
            end
            v_rdy_m = (n % 500 < 100) ? 8'($urandom() & $urandom() & $urandom()) : 8'($urandom());
            step();
        end
        vld_s = 1'b0; v_rdy_m = 8'hFF;
        repeat (3) step();

        // WIDTH=6: illegal index, sticky error and clear
        vld6 = 1'b1; dst6 = 3'd7; pld6 = 32'hDEAD_0007;
        #1;
        check("w6_illegal_rdy", {63'd0, rdy6}, 64'd1);
        check("w6_err_before", {63'd0, err6}, 64'd0);
        @(posedge clk); #1;
        check("w6_err_set", {63'd0, err6}, 64'd1);
        check("w6_no_vld", {58'd0, v_vld6}, 64'd0);
        vld6 = 1'b0;
        @(negedge clk);
        err_clr6 = 1'b1;
        @(posedge clk); #1;
        check("w6_err_clr", {63'd0, err6}, 64'd0);
        @(negedge clk);
        vld6 = 1'b1; dst6 = 3'd6; err_clr6 = 1'b1;
        @(posedge clk); #1;
        check("w6_set_wins", {63'd0, err6}, 64'd1);
        check("w6_no_vld2", {58'd0, v_vld6}, 64'd0);
        @(negedge clk);
        vld6 = 1'b1; dst6 = 3'd2; pld6 = 32'h0000_1234; err_clr6 = 1'b0;
        #1;
        check("w6_legal_rdy", {63'd0, rdy6}, 64'd1);
        @(posedge clk); #1;
        check("w6_vld", {58'd0, v_vld6}, 64'h04);
        check("w6_pld", {32'd0, v_pld6[2]}, 64'h1234);
        vld6 = 1'b0;
        @(negedge clk);

        // Reset mid-operation with queued data in both instances
        v_rdy_m = 8'h00; vld_s = 1'b1; dst_idx_s = 3'd4; pld_s = 32'h4444;
        step();
        vld_s = 1'b0;
        #1;
        check("pre_rst_vld", {56'd0, v_vld_m}, 64'h10);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", {56'd0, v_vld_m}, 64'd0);
        check("mid_rst_vld6", {58'd0, v_vld6}, 64'd0);
        check("mid_rst_err6", {63'd0, err6}, 64'd0);
        check("mid_rst_rdy", {63'd0, rdy_s}, 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
